// File: rtl/axi4_r_sender.sv
// R-channel output stage: forwards buffered read responses and injects error bursts for dropped reads at burst boundaries.
// Optional build macro AXI4_R_SENDER_PREFETCH_EN: adds drop_prefetch_i; prefetch drops are answered OKAY instead of SLVERR.
module axi4_r_sender #(
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned AXI_USER_WIDTH  = 4,
    parameter int unsigned DROP_FIFO_DEPTH = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arst,
    input  logic                      drop_i,
    input  logic [AXI_ID_WIDTH-1:0]   drop_id_i,
    input  logic [7:0]                drop_len_i,
    input  logic [AXI_USER_WIDTH-1:0] drop_user_i,
`ifdef AXI4_R_SENDER_PREFETCH_EN
    input  logic                      drop_prefetch_i,
`endif
    output logic                      drop_ready_o,
    output logic                      done_o,
    output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
    output logic [1:0]                s_axi4_rresp,
    output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
    output logic                      s_axi4_rlast,
    output logic                      s_axi4_rvalid,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
    input  logic                      s_axi4_rready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
    input  logic [1:0]                m_axi4_rresp,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
    input  logic                      m_axi4_rlast,
    input  logic                      m_axi4_rvalid,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
    output logic                      m_axi4_rready
);

    localparam int unsigned PTR_W = (DROP_FIFO_DEPTH > 1) ? $clog2(DROP_FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FWD, ERR} state_e;

    state_e state_q, state_d;

    logic [AXI_ID_WIDTH-1:0]   fifo_id_q   [DROP_FIFO_DEPTH];
    logic [7:0]                fifo_len_q  [DROP_FIFO_DEPTH];
    logic [AXI_USER_WIDTH-1:0] fifo_user_q [DROP_FIFO_DEPTH];
`ifdef AXI4_R_SENDER_PREFETCH_EN
    logic                      fifo_pf_q   [DROP_FIFO_DEPTH];
`endif
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q;
    logic [7:0]       cnt_q, cnt_d;

    logic full, empty, push, pop;
    logic err_mode, done;
    logic [1:0] err_resp;

    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [1:0]                rresp;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic                      rlast;
    logic                      rvalid;
    logic [AXI_USER_WIDTH-1:0] ruser;
    logic                      mready;

    assign full  = (fill_q == (PTR_W+1)'(DROP_FIFO_DEPTH));
    assign empty = (fill_q == '0);
    assign push  = drop_i & drop_ready_o;

`ifdef AXI4_R_SENDER_PREFETCH_EN
    assign err_resp = fifo_pf_q[rd_ptr_q] ? 2'b00 : 2'b10;
`else
    assign err_resp = 2'b10;
`endif

    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= drop_id_i;
            fifo_len_q[wr_ptr_q]  <= drop_len_i;
            fifo_user_q[wr_ptr_q] <= drop_user_i;
`ifdef AXI4_R_SENDER_PREFETCH_EN
            fifo_pf_q[wr_ptr_q]   <= drop_prefetch_i;
`endif
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fill_q <= fill_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // IDLE with a pending drop already behaves as ERR, so the first error beat appears the cycle after the push.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        done     = 1'b0;
        err_mode = (state_q == ERR) || ((state_q == IDLE) && !empty);
        rid      = m_axi4_rid;
        rresp    = m_axi4_rresp;
        rdata    = m_axi4_rdata;
        rlast    = m_axi4_rlast;
        ruser    = m_axi4_ruser;
        rvalid   = 1'b0;
        mready   = 1'b0;
        if (err_mode) begin
            rid    = fifo_id_q[rd_ptr_q];
            ruser  = fifo_user_q[rd_ptr_q];
            rdata  = '0;
            rresp  = err_resp;
            rlast  = (cnt_q == fifo_len_q[rd_ptr_q]);
            rvalid = 1'b1;
            if (s_axi4_rready) begin
                if (rlast) begin
                    pop     = 1'b1;
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ERR;
                end
            end
        end else begin
            rvalid = m_axi4_rvalid;
            mready = s_axi4_rready;
            if (m_axi4_rvalid && s_axi4_rready) begin
                state_d = m_axi4_rlast ? IDLE : FWD;
            end
        end
    end

    assign s_axi4_rid    = rid;
    assign s_axi4_rresp  = rresp;
    assign s_axi4_rdata  = rdata;
    assign s_axi4_rlast  = rlast;
    assign s_axi4_ruser  = ruser;
    assign s_axi4_rvalid = rvalid & ~axi4_arst;
    assign m_axi4_rready = mready & ~axi4_arst;
    assign done_o        = done & ~axi4_arst;
    assign drop_ready_o  = (~full | pop) & ~axi4_arst;

endmodule
